// File: rtl/axis_video_tpg_if.sv
// rtl/axis_video_tpg_if.sv - AXI4-Stream video beat bundle shared by the pattern generator and its sink
//
// Signals:
//   tvalid  source -> sink  beat valid
//   tready  sink -> source  beat ready
//   tdata   source -> sink  pixel {c2,c1,c0}, WIDTH bits
//   tlast   source -> sink  end of line
//   tuser   source -> sink  bit 0 = start of frame
// Modports: master (generator side), slave (consumer side).

interface axis_video_tpg_if #(
    parameter int WIDTH       = 48,
    parameter int TUSER_WIDTH = 1
) ();
    logic                   tvalid;
    logic                   tready;
    logic [WIDTH-1:0]       tdata;
    logic                   tlast;
    logic [TUSER_WIDTH-1:0] tuser;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        input  tuser,
        output tready
    );
endinterface

// File: rtl/axis_video_tpg.sv
// rtl/axis_video_tpg.sv - AXI4-Stream video test pattern generator (frames of H_ACTIVE x V_ACTIVE)
//
// Ports:
//   aclk         in   clock
//   aresetn      in   synchronous active-low reset
//   enable       in   run request, sampled in IDLE and at frame-gap exit
//   pattern_sel  in   0 colour bars, 1 ramp, 2 checker, 3 frame-count solid
//   m_axis       master stream (tvalid/tready/tdata/tlast/tuser), tuser[0] = SOF, tlast = EOL
//   frame_cnt    out  completed frames, wraps
//   busy         out  high while a frame or its trailing gap is in progress
//
// Optional build macro: TPG_LINE_GAP_EN adds H_GAP idle cycles after each
// non-final line. Without it lines are back-to-back and H_GAP is ignored.

module axis_video_tpg #(
    parameter int WIDTH       = 48,
    parameter int TUSER_WIDTH = 1,
    parameter int H_ACTIVE    = 1920,
    parameter int V_ACTIVE    = 1080,
    parameter int FRAME_GAP   = 1000,
    parameter int H_GAP       = 0
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          enable,
    input  logic [1:0]    pattern_sel,
    axis_video_tpg_if.master m_axis,
    output logic [15:0]   frame_cnt,
    output logic          busy
);

    localparam int          C       = WIDTH / 3;
    localparam int          BAR_LEN = H_ACTIVE / 8;
    localparam logic [15:0] X_LAST  = 16'(H_ACTIVE - 1);
    localparam logic [15:0] Y_LAST  = 16'(V_ACTIVE - 1);
    localparam logic [15:0] BAR_END = 16'(BAR_LEN - 1);
    localparam logic [31:0] FG_END  = 32'(FRAME_GAP - 1);
    localparam logic [31:0] LG_END  = 32'(H_GAP - 1);

`ifdef TPG_LINE_GAP_EN
    localparam bit LINE_GAP_EN = 1'b1;
`else
    localparam bit LINE_GAP_EN = 1'b0;
`endif

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_GAP    = 2'd2;
    localparam logic [1:0] S_LGAP   = 2'd3;

    logic [1:0]       state, state_n;
    logic [15:0]      x, x_n, y, y_n;
    logic [2:0]       bar, bar_n;
    logic [15:0]      bar_pos, bar_pos_n;
    logic [1:0]       pat, pat_n;
    logic [31:0]      gap_cnt, gap_n;
    logic [15:0]      fc_n;
    logic             tvalid_r, tvalid_n;
    logic [WIDTH-1:0] tdata_r;
    logic             tlast_r, tuser_r;
    logic             load, start, accept;

    // Pixel value for one beat; the three components are identical except in
    // colour-bar mode, where each component follows one bit of the bar index.
    function automatic logic [WIDTH-1:0] pixel(
        input logic [1:0]  p,
        input logic [15:0] ramp,
        input logic        chk,
        input logic [2:0]  b,
        input logic [15:0] fc
    );
        logic [C-1:0] maxv, c0, c1, c2;
        maxv = '1;
        case (p)
            2'd0: begin
                c2 = b[2] ? maxv : '0;
                c1 = b[1] ? maxv : '0;
                c0 = b[0] ? maxv : '0;
            end
            2'd1: begin
                c0 = C'(ramp);
                c1 = c0;
                c2 = c0;
            end
            2'd2: begin
                c0 = chk ? maxv : '0;
                c1 = c0;
                c2 = c0;
            end
            default: begin
                c0 = C'(fc);
                c1 = c0;
                c2 = c0;
            end
        endcase
        return WIDTH'({c2, c1, c0});
    endfunction

    assign accept = tvalid_r & m_axis.tready;

    always_comb begin
        state_n   = state;
        x_n       = x;
        y_n       = y;
        bar_n     = bar;
        bar_pos_n = bar_pos;
        pat_n     = pat;
        gap_n     = gap_cnt;
        fc_n      = frame_cnt;
        tvalid_n  = tvalid_r;
        load      = 1'b0;
        start     = 1'b0;

        case (state)
            S_IDLE: begin
                if (enable) start = 1'b1;
            end
            S_ACTIVE: begin
                if (accept) begin
                    if (x == X_LAST) begin
                        x_n       = 16'd0;
                        bar_n     = 3'd0;
                        bar_pos_n = 16'd0;
                        if (y == Y_LAST) begin
                            // End of frame: count it and drop valid for the frame gap.
                            y_n      = 16'd0;
                            fc_n     = frame_cnt + 16'd1;
                            state_n  = S_GAP;
                            gap_n    = 32'd0;
                            tvalid_n = 1'b0;
                        end else begin
                            y_n  = y + 16'd1;
                            load = 1'b1;
                            if (LINE_GAP_EN && H_GAP > 0) begin
                                state_n  = S_LGAP;
                                gap_n    = 32'd0;
                                tvalid_n = 1'b0;
                            end
                        end
                    end else begin
                        x_n  = x + 16'd1;
                        load = 1'b1;
                        // Bar index advances every H_ACTIVE/8 pixels without a divider.
                        if (bar_pos == BAR_END) begin
                            bar_pos_n = 16'd0;
                            bar_n     = bar + 3'd1;
                        end else begin
                            bar_pos_n = bar_pos + 16'd1;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == FG_END) begin
                    if (enable) start = 1'b1;
                    else        state_n = S_IDLE;
                end else begin
                    gap_n = gap_cnt + 32'd1;
                end
            end
`ifdef TPG_LINE_GAP_EN
            S_LGAP: begin
                // Next line's first beat was already loaded on entry; only valid is held off.
                if (gap_cnt == LG_END) begin
                    state_n  = S_ACTIVE;
                    tvalid_n = 1'b1;
                end else begin
                    gap_n = gap_cnt + 32'd1;
                end
            end
`endif
            default: state_n = S_IDLE;
        endcase

        // New frame: latch the pattern and present SOF on the next cycle.
        if (start) begin
            state_n   = S_ACTIVE;
            x_n       = 16'd0;
            y_n       = 16'd0;
            bar_n     = 3'd0;
            bar_pos_n = 16'd0;
            pat_n     = pattern_sel;
            tvalid_n  = 1'b1;
            load      = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state     <= S_IDLE;
            x         <= 16'd0;
            y         <= 16'd0;
            bar       <= 3'd0;
            bar_pos   <= 16'd0;
            pat       <= 2'd0;
            gap_cnt   <= 32'd0;
            frame_cnt <= 16'd0;
            tvalid_r  <= 1'b0;
            tdata_r   <= '0;
            tlast_r   <= 1'b0;
            tuser_r   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            x         <= x_n;
            y         <= y_n;
            bar       <= bar_n;
            bar_pos   <= bar_pos_n;
            pat       <= pat_n;
            gap_cnt   <= gap_n;
            frame_cnt <= fc_n;
            tvalid_r  <= tvalid_n;
            busy      <= (state_n != S_IDLE);
            if (load) begin
                tdata_r <= pixel(pat_n, x_n, x_n[5] ^ y_n[5], bar_n, fc_n);
                tlast_r <= (x_n == X_LAST);
                tuser_r <= (x_n == 16'd0) && (y_n == 16'd0);
            end
        end
    end

    assign m_axis.tvalid = tvalid_r;
    assign m_axis.tdata  = tdata_r;
    assign m_axis.tlast  = tlast_r;
    assign m_axis.tuser  = TUSER_WIDTH'(tuser_r);

endmodule
